// File: rtl/serial_cpu_pkg.sv
// Shared types and sizes for the bit-serial CPU datapath.
// Holds the word/register-index widths and the serializer state encoding.
package serial_cpu_pkg;

    localparam int WORD_W     = 16;
    localparam int REG_ADDR_W = 3;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_SHIFT,
        SER_WB
    } ser_state_t;

    // A 1-bit counter is still needed for a degenerate 1-bit word.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/reg_serializer_if.sv
// Register-file side and serial-ALU side signals of the operand serializer.
// The master modport is the requester/ALU side, the slave modport is the serializer.
interface reg_serializer_if
    import serial_cpu_pkg::*;
#(
    parameter int WIDTH  = WORD_W,
    parameter int ADDR_W = REG_ADDR_W
);

    logic              start;
    logic [WIDTH-1:0]  rs1_data;
    logic [WIDTH-1:0]  rs2_data;
    logic [ADDR_W-1:0] rd_in;
    logic              res_bit;

    logic              busy;
    logic              a_bit;
    logic              b_bit;
    logic              first_bit;
    logic              last_bit;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_rd;
    logic [WIDTH-1:0]  wb_data;
    logic              done;

    modport master (
        output start,
        output rs1_data,
        output rs2_data,
        output rd_in,
        output res_bit,
        input  busy,
        input  a_bit,
        input  b_bit,
        input  first_bit,
        input  last_bit,
        input  wb_en,
        input  wb_rd,
        input  wb_data,
        input  done
    );

    modport slave (
        input  start,
        input  rs1_data,
        input  rs2_data,
        input  rd_in,
        input  res_bit,
        output busy,
        output a_bit,
        output b_bit,
        output first_bit,
        output last_bit,
        output wb_en,
        output wb_rd,
        output wb_data,
        output done
    );

endinterface

// File: rtl/shift_reg16.sv
// Generic shift-right register: parallel load, serial in at MSB, serial out at LSB.
// Load takes priority over shift.
module shift_reg16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic             ser_i,
    input  logic [WIDTH-1:0] par_i,
    output logic             ser_o,
    output logic [WIDTH-1:0] par_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = par_i;
        end else if (shift_i) begin
            data_d = {ser_i, data_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign ser_o = data_q[0];
    assign par_o = data_q;

endmodule

// File: rtl/reg_serializer.sv
// Bit-serial operand streamer: captures two operands, streams them LSB-first to the
// serial ALU while collecting result bits, then issues a single register-file write.
module reg_serializer
    import serial_cpu_pkg::*;
#(
    parameter int WIDTH  = WORD_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input logic             clk,
    input logic             rst,
    reg_serializer_if.slave bus
);

    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    ser_state_t        state_q;
    ser_state_t        state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [ADDR_W-1:0] rd_q;
    logic [ADDR_W-1:0] rd_d;
    logic [WIDTH-1:0]  wb_data_q;
    logic [WIDTH-1:0]  wb_data_d;

    logic              accept;
    logic              in_shift;
    logic              a_ser;
    logic              b_ser;
    logic [WIDTH-1:0]  res_par;
    logic [WIDTH-1:0]  a_par_unused;
    logic [WIDTH-1:0]  b_par_unused;
    logic              res_ser_unused;

    shift_reg16 #(.WIDTH(WIDTH)) u_sr_a (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept),
        .shift_i (in_shift),
        .ser_i   (1'b0),
        .par_i   (bus.rs1_data),
        .ser_o   (a_ser),
        .par_o   (a_par_unused)
    );

    shift_reg16 #(.WIDTH(WIDTH)) u_sr_b (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept),
        .shift_i (in_shift),
        .ser_i   (1'b0),
        .par_i   (bus.rs2_data),
        .ser_o   (b_ser),
        .par_o   (b_par_unused)
    );

    // Result collector: a full WIDTH-bit shift overwrites every bit, so no clear on accept.
    shift_reg16 #(.WIDTH(WIDTH)) u_sr_res (
        .clk     (clk),
        .rst     (rst),
        .load_i  (1'b0),
        .shift_i (in_shift),
        .ser_i   (bus.res_bit),
        .par_i   ('0),
        .ser_o   (res_ser_unused),
        .par_o   (res_par)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        wb_data_d = wb_data_q;
        accept    = 1'b0;
        in_shift  = 1'b0;

        unique case (state_q)
            SER_IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    rd_d    = bus.rd_in;
                    cnt_d   = '0;
                    state_d = SER_SHIFT;
                end
            end
            SER_SHIFT: begin
                in_shift = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // Capture the final word including the bit arriving this cycle,
                    // so wb_data stays frozen while the next operation shifts.
                    wb_data_d = {bus.res_bit, res_par[WIDTH-1:1]};
                    state_d   = SER_WB;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SER_WB: begin
                state_d = SER_IDLE;
            end
            default: begin
                state_d = SER_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SER_IDLE;
            cnt_q     <= '0;
            rd_q      <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign bus.busy      = (state_q != SER_IDLE);
    assign bus.a_bit     = (state_q == SER_SHIFT) & a_ser;
    assign bus.b_bit     = (state_q == SER_SHIFT) & b_ser;
    assign bus.first_bit = (state_q == SER_SHIFT) && (cnt_q == '0);
    assign bus.last_bit  = (state_q == SER_SHIFT) && (cnt_q == CNT_LAST);
    assign bus.wb_en     = (state_q == SER_WB);
    assign bus.done      = (state_q == SER_WB);
    assign bus.wb_rd     = rd_q;
    assign bus.wb_data   = wb_data_q;

endmodule

// File: tb/tb_reg_serializer.sv
// Self-checking bench for reg_serializer: table of whole operations plus
// hand-written sequences for busy-ignore, back-to-back and reset corners.
module tb_reg_serializer;
    import serial_cpu_pkg::*;

    localparam int W = 16;

    typedef struct {
        logic [1:0]  mode;   // 0: pass a_bit, 1: serial add, 2: last_bit only
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  rd;
        logic [15:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reg_serializer_if #(.WIDTH(W), .ADDR_W(3)) bus ();

    reg_serializer #(.WIDTH(W), .ADDR_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] mode    = 2'd0;
    logic       carry_q = 1'b0;
    logic       cin;

    always_comb begin
        cin         = bus.first_bit ? 1'b0 : carry_q;
        bus.res_bit = 1'b0;
        case (mode)
            2'd0:    bus.res_bit = bus.a_bit;
            2'd1:    bus.res_bit = bus.a_bit ^ bus.b_bit ^ cin;
            2'd2:    bus.res_bit = bus.last_bit;
            default: bus.res_bit = 1'b0;
        endcase
    end

    always @(posedge clk)
        carry_q <= (bus.a_bit & bus.b_bit) | (bus.a_bit & cin) | (bus.b_bit & cin);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  {31'd0, bus.busy},      32'd0);
        chk({tag, "_abit"},  {31'd0, bus.a_bit},     32'd0);
        chk({tag, "_bbit"},  {31'd0, bus.b_bit},     32'd0);
        chk({tag, "_first"}, {31'd0, bus.first_bit}, 32'd0);
        chk({tag, "_last"},  {31'd0, bus.last_bit},  32'd0);
        chk({tag, "_wben"},  {31'd0, bus.wb_en},     32'd0);
        chk({tag, "_done"},  {31'd0, bus.done},      32'd0);
        chk({tag, "_wbrd"},  {29'd0, bus.wb_rd},     32'd0);
        chk({tag, "_wbdat"}, {16'd0, bus.wb_data},   32'd0);
    endtask

    // Runs one full operation starting at the current negedge; ends on cycle 18 (IDLE).
    task automatic run_vec(input vec_t v);
        mode         = v.mode;
        bus.rs1_data = v.a;
        bus.rs2_data = v.b;
        bus.rd_in    = v.rd;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.rs1_data = 16'hDEAD;
        bus.rs2_data = 16'hBEEF;
        bus.rd_in    = ~v.rd;
        for (int k = 0; k < W; k++) begin
            chk("vec_abit",  {31'd0, bus.a_bit},     {31'd0, v.a[k]});
            chk("vec_bbit",  {31'd0, bus.b_bit},     {31'd0, v.b[k]});
            chk("vec_first", {31'd0, bus.first_bit}, (k == 0)     ? 32'd1 : 32'd0);
            chk("vec_last",  {31'd0, bus.last_bit},  (k == W - 1) ? 32'd1 : 32'd0);
            chk("vec_busy",  {31'd0, bus.busy},      32'd1);
            chk("vec_wben",  {31'd0, bus.wb_en},     32'd0);
            tick();
        end
        chk("vec_wb_en",   {31'd0, bus.wb_en}, 32'd1);
        chk("vec_wb_done", {31'd0, bus.done},  32'd1);
        chk("vec_wb_busy", {31'd0, bus.busy},  32'd1);
        chk("vec_wb_rd",   {29'd0, bus.wb_rd},   {29'd0, v.rd});
        chk("vec_wb_data", {16'd0, bus.wb_data}, {16'd0, v.exp});
        tick();
        chk("vec_post_busy", {31'd0, bus.busy},    32'd0);
        chk("vec_post_wben", {31'd0, bus.wb_en},   32'd0);
        chk("vec_post_hold", {16'd0, bus.wb_data}, {16'd0, v.exp});
    endtask

    vec_t vecs[7];

    initial begin
        logic [15:0] a_first;
        int          wb_cnt;
        int          wb_c1;
        int          wb_c2;
        logic [15:0] wb_d1;
        logic [15:0] wb_d2;
        logic [2:0]  wb_r1;
        logic [2:0]  wb_r2;

        vecs[0] = '{mode: 2'd0, a: 16'hA5C3, b: 16'h0000, rd: 3'd5, exp: 16'hA5C3};
        vecs[1] = '{mode: 2'd1, a: 16'hFFFF, b: 16'h0001, rd: 3'd2, exp: 16'h0000};
        vecs[2] = '{mode: 2'd1, a: 16'h1234, b: 16'h4321, rd: 3'd7, exp: 16'h5555};
        vecs[3] = '{mode: 2'd2, a: 16'h1234, b: 16'h0F0F, rd: 3'd1, exp: 16'h8000};
        vecs[4] = '{mode: 2'd1, a: 16'h00FF, b: 16'h0001, rd: 3'd3, exp: 16'h0100};
        vecs[5] = '{mode: 2'd1, a: 16'h8000, b: 16'h8000, rd: 3'd6, exp: 16'h0000};
        vecs[6] = '{mode: 2'd0, a: 16'hFFFF, b: 16'hAAAA, rd: 3'd4, exp: 16'hFFFF};

        bus.start    = 1'b0;
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        bus.rd_in    = '0;

        #1 rst = 1'b1;
        #1 chk_all_zero("reset");
        repeat (2) tick();
        rst = 1'b0;
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Busy ignore: start pulses in SHIFT (3, 10) and WB (17), re-accept at 18.
        mode         = 2'd0;
        a_first      = 16'hA5C3;
        bus.rs1_data = a_first;
        bus.rs2_data = 16'h0000;
        bus.rd_in    = 3'd5;
        bus.start    = 1'b1;
        tick();
        for (int c = 1; c <= 36; c++) begin
            bus.start = (c == 3 || c == 10 || c == 17 || c == 18);
            if (c == 18) begin
                bus.rs1_data = 16'h0F0F;
                bus.rd_in    = 3'd4;
            end else if (bus.start) begin
                bus.rs1_data = 16'hFFFF;
                bus.rd_in    = 3'd1;
            end
            if (c <= 16) chk("ign_abit", {31'd0, bus.a_bit}, {31'd0, a_first[c-1]});
            if (c == 17) begin
                chk("ign_wb_en",   {31'd0, bus.wb_en},   32'd1);
                chk("ign_wb_data", {16'd0, bus.wb_data}, 32'h0000A5C3);
                chk("ign_wb_rd",   {29'd0, bus.wb_rd},   32'd5);
            end
            if (c == 18) chk("ign_idle_busy", {31'd0, bus.busy}, 32'd0);
            if (c == 19) begin
                chk("ign_reacc_busy",  {31'd0, bus.busy},      32'd1);
                chk("ign_reacc_first", {31'd0, bus.first_bit}, 32'd1);
                chk("ign_reacc_abit",  {31'd0, bus.a_bit},     32'd1);
            end
            if (c == 35) begin
                chk("ign2_wb_en",   {31'd0, bus.wb_en},   32'd1);
                chk("ign2_wb_data", {16'd0, bus.wb_data}, 32'h00000F0F);
                chk("ign2_wb_rd",   {29'd0, bus.wb_rd},   32'd4);
            end
            if (c == 36) chk("ign2_post_busy", {31'd0, bus.busy}, 32'd0);
            tick();
        end
        bus.start = 1'b0;

        // Back-to-back with start held high through the first re-accept.
        mode         = 2'd0;
        bus.rs1_data = 16'h1234;
        bus.rd_in    = 3'd2;
        bus.start    = 1'b1;
        wb_cnt = 0; wb_c1 = 0; wb_c2 = 0;
        wb_d1 = '0; wb_d2 = '0; wb_r1 = '0; wb_r2 = '0;
        tick();
        for (int c = 1; c <= 45; c++) begin
            bus.start = (c <= 18);
            if (c == 1) begin
                bus.rs1_data = 16'h8001;
                bus.rd_in    = 3'd6;
            end
            if (bus.wb_en) begin
                wb_cnt++;
                if (wb_cnt == 1) begin
                    wb_c1 = c; wb_d1 = bus.wb_data; wb_r1 = bus.wb_rd;
                end else begin
                    wb_c2 = c; wb_d2 = bus.wb_data; wb_r2 = bus.wb_rd;
                end
            end
            if (c == 20) chk("b2b_hold", {16'd0, bus.wb_data}, 32'h00001234);
            tick();
        end
        chk("b2b_count",   wb_cnt, 32'd2);
        chk("b2b_first_c", wb_c1,  32'd17);
        chk("b2b_spacing", wb_c2 - wb_c1, 32'd18);
        chk("b2b_data1",   {16'd0, wb_d1}, 32'h00001234);
        chk("b2b_rd1",     {29'd0, wb_r1}, 32'd2);
        chk("b2b_data2",   {16'd0, wb_d2}, 32'h00008001);
        chk("b2b_rd2",     {29'd0, wb_r2}, 32'd6);

        // Reset mid-SHIFT: outputs clear at once and no writeback follows.
        bus.rs1_data = 16'hFFFF;
        bus.rd_in    = 3'd7;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (7) tick();
        chk("rst_pre_busy", {31'd0, bus.busy}, 32'd1);
        #2 rst = 1'b1;
        #1 chk_all_zero("rst_shift");
        repeat (2) tick();
        rst = 1'b0;
        wb_cnt = 0;
        for (int c = 0; c < 25; c++) begin
            if (bus.wb_en) wb_cnt++;
            tick();
        end
        chk("rst_shift_no_wb", wb_cnt, 32'd0);

        // Reset during WB, then accept on the first edge after release.
        bus.rs1_data = 16'h1111;
        bus.rd_in    = 3'd3;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (16) tick();
        chk("rstwb_pre_wben", {31'd0, bus.wb_en}, 32'd1);
        #2 rst = 1'b1;
        #1 chk_all_zero("rst_wb");
        tick();
        rst          = 1'b0;
        bus.rs1_data = 16'h3C3C;
        bus.rd_in    = 3'd7;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("rstwb_acc_busy",  {31'd0, bus.busy},      32'd1);
        chk("rstwb_acc_first", {31'd0, bus.first_bit}, 32'd1);
        repeat (16) tick();
        chk("rstwb_wb_en",   {31'd0, bus.wb_en},   32'd1);
        chk("rstwb_wb_data", {16'd0, bus.wb_data}, 32'h00003C3C);
        chk("rstwb_wb_rd",   {29'd0, bus.wb_rd},   32'd7);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_serializer.md
# reg_serializer

Bit-serial operand streamer between the register file and the serial ALU. On `start`, it captures two 16-bit source operands and the destination index. It then shifts both operands out LSB-first, one bit per cycle, while shifting the ALU result bits back in. It finishes with a single-cycle writeback to the register file. It is the reading/writing counterpart that drives the register file ports from the serial datapath side.

## Interface
Parameters:
- `WIDTH`, 16, operand width in bits; also the shift count.
- `ADDR_W`, 3, register index width (8 registers).

Ports:
- `clk`  in  1  single system clock; all state is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request to begin an operation; accepted only when `busy`=0.
- `rs1_data`  in  WIDTH  operand A, sampled on the accept cycle.
- `rs2_data`  in  WIDTH  operand B, sampled on the accept cycle.
- `rd_in`  in  ADDR_W  destination index, sampled on the accept cycle.
- `res_bit`  in  1  ALU result bit for the current bit position; combinational from `a_bit`/`b_bit`.
- `busy`  out  1  high from the cycle after accept through the writeback cycle.
- `a_bit`  out  1  current bit of operand A.
- `b_bit`  out  1  current bit of operand B.
- `first_bit`  out  1  high while bit 0 is presented; the ALU uses it to load carry-in.
- `last_bit`  out  1  high while bit WIDTH-1 is presented.
- `wb_en`  out  1  one-cycle register file write strobe.
- `wb_rd`  out  ADDR_W  write index, valid while `wb_en`=1.
- `wb_data`  out  WIDTH  assembled result, valid while `wb_en`=1.
- `done`  out  1  one-cycle pulse, coincident with `wb_en`.

## Operation
- FSM states are IDLE, SHIFT and WB. Reset enters IDLE.
- **IDLE:** `busy`=0. When `start`=1, latch `rs1_data`, `rs2_data` and `rd_in`, clear the bit counter, and go to SHIFT.
- **SHIFT:** runs for exactly WIDTH cycles.
  - In cycle k (k=0..WIDTH-1), `a_bit`=A[k] and `b_bit`=B[k].
  - `res_bit` is sampled at the end of cycle k into result bit k. The result register shifts right with `res_bit` entering at the MSB.
  - The counter increments each cycle. After the cycle with count=WIDTH-1, go to WB.
- **WB:** `wb_en`=1 and `done`=1 for one cycle, with `wb_rd` equal to the latched rd. Then return to IDLE.
- `start` while `busy`=1 is ignored and not queued. `start` in the WB cycle is also ignored; the earliest re-accept is the IDLE cycle that follows.
- Forwarding is the register file's job. This block does not compare rd against sources.
- `first_bit` = SHIFT && count==0. `last_bit` = SHIFT && count==WIDTH-1.
- Outside SHIFT, `a_bit`, `b_bit`, `first_bit` and `last_bit` are 0.

## Timing
- Reset values: `busy`=0, `a_bit`=0, `b_bit`=0, `first_bit`=0, `last_bit`=0, `wb_en`=0, `done`=0, `wb_rd`=0, `wb_data`=0. Internal counter and shift registers are also 0.
- Accept at edge T0. Bit 0 is presented in the cycle after T0; bit WIDTH-1 is presented WIDTH cycles after T0.
- `wb_en` is asserted in cycle T0+WIDTH+1, giving WIDTH+2 cycles from the `start` cycle to `done`.
- Throughput is one operation per WIDTH+2 cycles.
- Operand shift outputs are registered (they come from shift-register LSBs). `first_bit` and `last_bit` are decoded from registered state.
- `wb_data` is held between operations and only updates when the result shift completes.
- The counter is ceil(log2(WIDTH)) bits wide. Reaching WIDTH-1 is the sole exit from SHIFT; there is no wrap past it.
- `rst` asserted mid-SHIFT or in WB: return to IDLE immediately (asynchronously), with all outputs at their reset values. A write interrupted this way must not produce `wb_en`.
- After `rst` deasserts, the first possible accept is the next rising edge.

## Structure
- Shared package `serial_cpu_pkg` holds:
  - `WORD_W` = 16 and `REG_ADDR_W` = 3;
  - `typedef logic [WORD_W-1:0] word_t`;
  - `typedef enum logic [1:0] {SER_IDLE, SER_SHIFT, SER_WB} ser_state_t`.
- One sub-module, `shift_reg16`: a generic WIDTH-bit shift-right register with parallel load, serial in at the MSB, serial out at the LSB, and async reset.
  - Instantiate it three times: A and B as PISO; the result as SIPO with its parallel output.
- Top-level RTL is the FSM, counter and flag decode.

## Test plan
- Reset: assert `rst` mid-run → all outputs 0 and no `wb_en` pulse; after release, `start` is accepted on the next edge.
- Pass-through: A=0xA5C3, B=0, model `res_bit`=`a_bit`, rd=5 → bits stream LSB-first as 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; `wb_en` is asserted 17 cycles after accept with `wb_rd`=5 and `wb_data`=0xA5C3.
- Serial add: A=0xFFFF, B=0x0001, model a full adder with carry cleared on `first_bit` → `wb_data`=0x0000, `first_bit`/`last_bit` each high for exactly one cycle.
- Busy ignore: pulse `start` with new operands at cycles 3, 10 and 17 after accept (17 = WB) → the first result is unaffected and no second operation starts; `start` at 18 is accepted.
- Back-to-back: hold `start`=1 continuously with A=0x1234 then 0x8001 → two writebacks spaced exactly 18 cycles apart, with correct data.
- Result assembly: `res_bit` forced to 1 only when `last_bit`=1 → `wb_data`=0x8000.
